mul_accumulator: RTL and testbench

MUL_ACCUMULATOR -- requirements
Module: mul_accumulator

---
 rtl/mul_accumulator_pkg.sv | 12 +
 rtl/mul_accumulator_sat_adder.sv | 15 +
 rtl/mul_accumulator.sv | 78 +++++++
 tb/tb_mul_accumulator.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_accumulator_pkg.sv
// Shared types and width defaults for the multiply-accumulate back end.
package mul_accumulator_pkg;
  localparam int ACC_W_DEF = 40;
  localparam int LEN_W_DEF = 8;
  localparam int PROD_W    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/mul_accumulator_sat_adder.sv
// Unsigned W-bit adder that clamps to all ones on carry-out and flags it.
module sat_adder #(
  parameter int W = 40
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);
  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_ovf  = w_full[W];
  assign o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
endmodule

// File: rtl/mul_accumulator.sv
// Sums a counted burst of 32-bit products into a saturating accumulator,
// pulsing done for one cycle after the last accepted product.
module mul_accumulator
  import mul_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              done,
  output logic              busy,
  output logic              overflow
);
  state_e             r_state, w_next;
  logic [ACC_W-1:0]   r_acc;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-1:0]   w_sum;
  logic               w_add_ovf;
  logic               w_accept;
  logic               w_last;

  assign w_prod_ext = ACC_W'(prod);
  assign w_accept   = (r_state == ACCUM) && prod_valid;
  assign w_last     = (r_cnt == LEN_W'(1));

  sat_adder #(.W(ACC_W)) u_add (
    .i_a   (r_acc),
    .i_b   (w_prod_ext),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (w_accept && w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
        r_cnt <= len;
      end else if (w_accept) begin
        // once saturated the adder keeps carrying out, so r_acc stays at all ones
        r_acc <= w_sum;
        r_ovf <= r_ovf | w_add_ovf;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign prod_ready = (r_state == ACCUM);
  assign done       = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign acc_out    = r_acc;
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_mul_accumulator.sv
// Drives identical traffic into a 40-bit and a 33-bit accumulator and checks
// both against an arithmetic model of a clamped running sum.
module tb_mul_accumulator;
  logic        clk = 1'b0;
  logic        rst, start, prod_valid;
  logic [7:0]  len;
  logic [31:0] prod;
  logic        rdy40, done40, busy40, ovf40;
  logic        rdy33, done33, busy33, ovf33;
  logic [39:0] acc40;
  logic [32:0] acc33;

  int ncmp = 0;
  int nerr = 0;
  logic [31:0] pq[$];

  always #5 clk = ~clk;

  mul_accumulator #(.ACC_W(40), .LEN_W(8)) dut40 (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod_valid(prod_valid),
    .prod(prod), .prod_ready(rdy40), .acc_out(acc40), .done(done40),
    .busy(busy40), .overflow(ovf40));

  mul_accumulator #(.ACC_W(33), .LEN_W(8)) dut33 (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod_valid(prod_valid),
    .prod(prod), .prod_ready(rdy33), .acc_out(acc33), .done(done33),
    .busy(busy33), .overflow(ovf33));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain running sum of pq, clamped to 2^w-1.
  function automatic longint unsigned model_sum(input int w, output bit ovf);
    longint unsigned mx, s;
    mx = (64'd1 << w) - 64'd1;
    s = 0; ovf = 1'b0;
    foreach (pq[i]) begin
      s = s + 64'(pq[i]);
      if (s > mx) begin s = mx; ovf = 1'b1; end
    end
    return s;
  endfunction

  // Runs one operation over pq with up to maxgap idle cycles before each
  // product; returns with the DUTs in the cycle after the last acceptance.
  task automatic do_op(input int maxgap, output bit early, output bit saw_rdy_bad,
                       output bit saw_rdy);
    early = 0; saw_rdy_bad = 0; saw_rdy = 0;
    start = 1'b1; len = 8'(pq.size()); prod_valid = 1'b0;
    step();
    start = 1'b0;
    foreach (pq[i]) begin
      int g;
      g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      for (int k = 0; k < g; k++) begin
        prod_valid = 1'b0; prod = $urandom;
        step();
        if (done40 || done33) early = 1;
      end
      prod_valid = 1'b1; prod = pq[i];
      if (!rdy40 || !rdy33) saw_rdy_bad = 1;
      if (rdy40 || rdy33) saw_rdy = 1;
      step();
      if (i != pq.size() - 1 && (done40 || done33)) early = 1;
    end
    prod_valid = 1'b0;
    if (rdy40 || rdy33) saw_rdy = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; len = 8'd5; prod_valid = 1'b1; prod = 32'hFFFF_FFFF;
    step(); step(); step();
    ncmp++; if ({rdy40, done40, busy40, ovf40} !== 4'b0 || acc40 !== 40'd0) begin
      nerr++; $display("FAIL reset40 got rdy/done/busy/ovf=%b acc=%h want 0000 acc=0", {rdy40, done40, busy40, ovf40}, acc40); end
    ncmp++; if ({rdy33, done33, busy33, ovf33} !== 4'b0 || acc33 !== 33'd0) begin
      nerr++; $display("FAIL reset33 got rdy/done/busy/ovf=%b acc=%h want 0000 acc=0", {rdy33, done33, busy33, ovf33}, acc33); end
    rst = 1'b0; start = 1'b0; prod_valid = 1'b0;
    step();
  endtask

  task automatic test_basic();
    bit e, rb, rs, o;
    pq = '{32'd6, 32'd15, 32'd100};
    do_op(0, e, rb, rs);
    ncmp++; if (e || rb) begin nerr++; $display("FAIL basic_hs got early=%0d rdy_low=%0d want 0 0", e, rb); end
    ncmp++; if (done40 !== 1'b1 || done33 !== 1'b1) begin
      nerr++; $display("FAIL basic_done got %b/%b want 1/1", done40, done33); end
    ncmp++; if (acc40 !== 40'd121 || ovf40 !== 1'b0) begin
      nerr++; $display("FAIL basic_acc got %0d ovf=%b want 121 ovf=0", acc40, ovf40); end
    ncmp++; if (64'(acc33) !== model_sum(33, o)) begin
      nerr++; $display("FAIL basic_acc33 got %0d want %0d", acc33, model_sum(33, o)); end
    step();
    ncmp++; if (done40 !== 1'b0 || busy40 !== 1'b0 || acc40 !== 40'd121) begin
      nerr++; $display("FAIL basic_after got done=%b busy=%b acc=%0d want 0 0 121", done40, busy40, acc40); end
  endtask

  task automatic test_gaps();
    bit e, rb, rs;
    pq = '{32'hFFFE_0001, 32'hFFFE_0001};
    start = 1'b1; len = 8'd2; step(); start = 1'b0;
    prod_valid = 1'b1; prod = pq[0]; step();
    prod_valid = 1'b0; e = 0;
    for (int k = 0; k < 4; k++) begin step(); if (done40 || done33 || !rdy40) e = 1; end
    prod_valid = 1'b1; prod = pq[1]; step(); prod_valid = 1'b0;
    ncmp++; if (e) begin nerr++; $display("FAIL gap_stall got early done or ready drop want stall"); end
    ncmp++; if (done40 !== 1'b1 || acc40 !== 40'h1_FFFC_0002 || acc33 !== 33'h1_FFFC_0002) begin
      nerr++; $display("FAIL gap_acc got done=%b acc40=%h acc33=%h want 1 1fffc0002", done40, acc40, acc33); end
    step();
  endtask

  task automatic test_saturate();
    bit e, rb, rs;
    pq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    do_op(1, e, rb, rs);
    ncmp++; if (acc33 !== 33'h1_FFFF_FFFF || ovf33 !== 1'b1 || done33 !== 1'b1) begin
      nerr++; $display("FAIL sat33 got acc=%h ovf=%b done=%b want 1ffffffff 1 1", acc33, ovf33, done33); end
    ncmp++; if (acc40 !== 40'h2_FFFF_FFFD || ovf40 !== 1'b0) begin
      nerr++; $display("FAIL sat40 got acc=%h ovf=%b want 2fffffffd 0", acc40, ovf40); end
    step(); step();
    ncmp++; if (ovf33 !== 1'b1 || acc33 !== 33'h1_FFFF_FFFF) begin
      nerr++; $display("FAIL sat_hold got ovf=%b acc=%h want 1 1ffffffff", ovf33, acc33); end
  endtask

  task automatic test_len0();
    bit e, rb, rs;
    pq.delete();
    do_op(0, e, rb, rs);
    ncmp++; if (done40 !== 1'b1 || done33 !== 1'b1 || acc40 !== 40'd0 || acc33 !== 33'd0 || ovf33 !== 1'b0) begin
      nerr++; $display("FAIL len0 got done=%b/%b acc=%h/%h ovf33=%b want 1/1 0/0 0", done40, done33, acc40, acc33, ovf33); end
    ncmp++; if (rs) begin nerr++; $display("FAIL len0_ready got ready=1 want 0"); end
    step();
    ncmp++; if (busy40 !== 1'b0 || done40 !== 1'b0) begin
      nerr++; $display("FAIL len0_after got busy=%b done=%b want 0 0", busy40, done40); end
  endtask

  task automatic test_reset_mid();
    bit e, rb, rs, sawd;
    start = 1'b1; len = 8'd4; step(); start = 1'b0;
    prod_valid = 1'b1; prod = 32'd1000; step();
    prod = 32'd2000; step();
    rst = 1'b1; prod = 32'd3000; step();
    rst = 1'b0; prod_valid = 1'b0;
    ncmp++; if (acc40 !== 40'd0 || busy40 !== 1'b0 || rdy40 !== 1'b0 || done40 !== 1'b0) begin
      nerr++; $display("FAIL rstmid got acc=%0d busy=%b rdy=%b done=%b want 0 0 0 0", acc40, busy40, rdy40, done40); end
    sawd = 0;
    for (int k = 0; k < 4; k++) begin step(); if (done40 || done33) sawd = 1; end
    ncmp++; if (sawd) begin nerr++; $display("FAIL rstmid_done got done pulse want none"); end
    pq = '{32'd7};
    do_op(0, e, rb, rs);
    ncmp++; if (acc40 !== 40'd7 || done40 !== 1'b1) begin
      nerr++; $display("FAIL rstmid_new got acc=%0d done=%b want 7 1", acc40, done40); end
    step();
  endtask

  task automatic test_start_ignored();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    start = 1'b1; len = 8'd2; step();
    len = 8'd9; prod_valid = 1'b1; prod = a; step();
    start = 1'b0; prod = b; step(); prod_valid = 1'b0;
    ncmp++; if (done40 !== 1'b1 || acc40 !== 40'(64'(a) + 64'(b))) begin
      nerr++; $display("FAIL startign got done=%b acc=%h want 1 %h", done40, acc40, 40'(64'(a) + 64'(b))); end
    step();
    ncmp++; if (busy40 !== 1'b0 || done40 !== 1'b0) begin
      nerr++; $display("FAIL startign_after got busy=%b done=%b want 0 0", busy40, done40); end
  endtask

  task automatic test_random();
    bit e, rb, rs, o40, o33;
    longint unsigned x40, x33;
    for (int t = 0; t < 25; t++) begin
      int n;
      n = $urandom_range(0, 6);
      pq.delete();
      for (int i = 0; i < n; i++) pq.push_back(($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom);
      x40 = model_sum(40, o40); x33 = model_sum(33, o33);
      do_op(2, e, rb, rs);
      ncmp++; if (e || rb || done40 !== 1'b1 || done33 !== 1'b1) begin
        nerr++; $display("FAIL rnd%0d_hs got early=%0d rdylow=%0d done=%b/%b want 0 0 1/1", t, e, rb, done40, done33); end
      ncmp++; if (64'(acc40) !== x40 || ovf40 !== o40) begin
        nerr++; $display("FAIL rnd%0d_acc40 got %h ovf=%b want %h ovf=%b", t, acc40, ovf40, x40, o40); end
      ncmp++; if (64'(acc33) !== x33 || ovf33 !== o33) begin
        nerr++; $display("FAIL rnd%0d_acc33 got %h ovf=%b want %h ovf=%b", t, acc33, ovf33, x33, o33); end
      // idle with valid traffic: nothing may change
      prod_valid = 1'b1; prod = $urandom; step(); step();
      prod_valid = 1'b0;
      ncmp++; if (64'(acc33) !== x33 || rdy33 !== 1'b0 || busy33 !== 1'b0) begin
        nerr++; $display("FAIL rnd%0d_idle got acc=%h rdy=%b busy=%b want %h 0 0", t, acc33, rdy33, busy33, x33); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0; prod = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_saturate();
    test_len0();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
